// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue holding {pc, instr} pairs between instruction memory and decode.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    // Explicit wrap keeps DEPTH=1 correct where the pointer cannot shrink to 0 bits.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, reads instruction memory, feeds decode via the prefetch queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = 16,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [31:0]       im_rd,
    input  logic              redir_valid,
    input  logic [31:0]       redir_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc
);

    logic [31:0]  fpc;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    fetch_entry_t din;
    fetch_entry_t head;

    // A redirect swallows any same-cycle pop and suppresses the push of the stale word.
    assign pop  = !empty && out_ready && !redir_valid;
    assign push = !redir_valid && (!full || pop);

    assign din.pc    = fpc;
    assign din.instr = im_rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc <= RESET_PC;
        end else if (redir_valid) begin
            fpc <= {redir_pc[31:2], 2'b00};
        end else if (push) begin
            fpc <= fpc + 32'd4;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redir_valid),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign im_addr   = fpc[ADDR_W-1:0];
    assign out_valid = !empty;
    assign out_instr = empty ? 32'd0 : head.instr;
    assign out_pc    = empty ? 32'd0 : head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-level reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic [15:0] im_addr;
    logic [31:0] im_rd;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic        rst_w;
    logic [15:0] im_addr_w;
    logic [31:0] im_rd_w;
    logic        ov_w;
    logic [31:0] oi_w;
    logic [31:0] op_w;

    logic [31:0] mem [0:16383];

    int checks   = 0;
    int failures = 0;

    fetch_entry_t q[$];
    logic [31:0]  mpc;
    logic [31:0]  last_pc;
    logic         have_last;

    fetch_unit #(.RESET_PC(32'h0), .ADDR_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_rd(im_rd),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    fetch_unit #(.RESET_PC(32'h0000_FFF8), .ADDR_W(16), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst_n(rst_w), .im_addr(im_addr_w), .im_rd(im_rd_w),
        .redir_valid(1'b0), .redir_pc(32'h0),
        .out_valid(ov_w), .out_ready(1'b1),
        .out_instr(oi_w), .out_pc(op_w)
    );

    assign im_rd   = mem[im_addr[15:2]];
    assign im_rd_w = mem[im_addr_w[15:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the reference model, then compare after the edge.
    task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
        fetch_entry_t e;
        rst_n       = r;
        redir_valid = rv;
        redir_pc    = rp;
        out_ready   = rdy;
        #1;
        if (r && !rv && rdy && out_valid === 1'b1) begin
            if (have_last) chk("order", out_pc, last_pc + 32'd4);
            last_pc   = out_pc;
            have_last = 1'b1;
        end
        if (!r || rv) have_last = 1'b0;

        if (!r) begin
            q.delete();
            mpc = 32'h0;
        end else if (rv) begin
            q.delete();
            mpc = rp & ~32'd3;
        end else begin
            if (rdy && q.size() > 0) void'(q.pop_front());
            if (q.size() < DEPTH) begin
                e.pc    = mpc;
                e.instr = mem[mpc[15:2]];
                q.push_back(e);
                mpc = mpc + 32'd4;
            end
        end

        @(posedge clk);
        #1;
        chk("valid",   32'(out_valid), 32'(q.size() != 0));
        chk("pc",      out_pc,    (q.size() != 0) ? q[0].pc    : 32'h0);
        chk("instr",   out_instr, (q.size() != 0) ? q[0].instr : 32'h0);
        chk("im_addr", 32'(im_addr), 32'(mpc[15:0]));
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_2283;
        mem[1] = 32'h0010_0393;
        mem[2] = 32'h0000_0e13;
        q.delete();
        mpc       = 32'h0;
        last_pc   = 32'h0;
        have_last = 1'b0;
        rst_w     = 1'b0;

        // Reset, with the wrap instance held in reset alongside.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst_valid",   32'(out_valid), 32'h0);
        chk("rst_pc",      out_pc, 32'h0);
        chk("rst_im_addr", 32'(im_addr), 32'h0);
        chk("w_rst_im",    32'(im_addr_w), 32'h0000_FFF8);
        chk("w_rst_valid", 32'(ov_w), 32'h0);

        // Streaming from reset; wrap instance released at the same time.
        rst_w = 1'b1;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("s0_pc", out_pc, 32'h0);
        chk("s0_in", out_instr, 32'h0000_2283);
        chk("w0_pc", op_w, 32'h0000_FFF8);
        chk("w0_im", 32'(im_addr_w), 32'h0000_FFFC);
        chk("w0_in", oi_w, mem[16382]);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("s1_pc", out_pc, 32'h4);
        chk("s1_in", out_instr, 32'h0010_0393);
        chk("w1_pc", op_w, 32'h0000_FFFC);
        chk("w1_im", 32'(im_addr_w), 32'h0000_0000);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("s2_pc", out_pc, 32'h8);
        chk("s2_in", out_instr, 32'h0000_0e13);
        chk("w2_pc", op_w, 32'h0001_0000);
        chk("w2_in", oi_w, 32'h0000_2283);

        // Backpressure after a fresh reset.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("bp_im",    32'(im_addr), 32'h8);
        chk("bp_pc",    out_pc, 32'h0);
        chk("bp_instr", out_instr, 32'h0000_2283);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("bp_pc1", out_pc, 32'h4);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("bp_pc2", out_pc, 32'h8);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("bp_pc3", out_pc, 32'hC);

        // Redirect while full.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_003C, 1'b0);
        chk("rd_valid", 32'(out_valid), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("rd_pc",    out_pc, 32'h3C);
        chk("rd_instr", out_instr, mem[15]);

        // Redirect coinciding with a pop, misaligned target.
        step(1'b1, 1'b1, 32'h0000_0045, 1'b1);
        chk("rp_valid", 32'(out_valid), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("rp_pc", out_pc, 32'h44);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("rp_pc2", out_pc, 32'h48);

        // Reset mid-stream with two entries queued.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("mr_valid", 32'(out_valid), 32'h0);
        chk("mr_pc",    out_pc, 32'h0);
        chk("mr_im",    32'(im_addr), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("mr_pc0", out_pc, 32'h0);
        chk("mr_in0", out_instr, 32'h0000_2283);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom,
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
